// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS32 pipeline.
// Resolves operand forwarding, computes the ALU result and registers it, the
// store data, the destination address and the controls into the EX/MEM boundary.
// Optional macro EX_MULT_EN: when defined, alu_op 1100 (MULT) runs on an
// iterative shift-add multiplier (IDLE/BUSY/DONE) that stalls the upstream
// stages. When undefined, 1100 is an undefined code (result 0, latency 1)
// and stall is tied low.
module ex_stage #(
    parameter int MULT_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_dst_in,
    input  logic        reg_write_in,
    input  logic        alu_src_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_to_reg_in,
    input  logic [3:0]  alu_op_in,
    input  logic [31:0] r_data1,
    input  logic [31:0] r_data2,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] mem_wb_result,
    input  logic        flush,
    output logic [31:0] alu_result,
    output logic [31:0] write_data,
    output logic [4:0]  w_addr,
    output logic        zero_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [1:0]  mem_to_reg_out,
    output logic        stall
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;

    logic [31:0] a_op;
    logic [31:0] bf_op;
    logic [31:0] b_op;
    logic [31:0] alu_val;
    logic [4:0]  shamt;
    logic [4:0]  dest;

    // Values captured into EX/MEM at the next edge
    logic [31:0] res_next;
    logic [31:0] wdata_next;
    logic [4:0]  waddr_next;
    logic        rw_next;
    logic        mr_next;
    logic        mw_next;
    logic [1:0]  m2r_next;

    assign shamt = imm[10:6];
    assign dest  = reg_dst_in ? rd : rt;
    assign b_op  = alu_src_in ? imm : bf_op;

    // Forwarding muxes for both operands (00 and 11 both select the register)
    always_comb begin
        case (fwd_a)
            2'b01:   a_op = mem_wb_result;
            2'b10:   a_op = ex_mem_result;
            default: a_op = r_data1;
        endcase
        case (fwd_b)
            2'b01:   bf_op = mem_wb_result;
            2'b10:   bf_op = ex_mem_result;
            default: bf_op = r_data2;
        endcase
    end

    // Single-cycle ALU; shifts act on the forwarded B operand, never on imm
    always_comb begin
        case (alu_op_in)
            OP_AND:  alu_val = a_op & b_op;
            OP_OR:   alu_val = a_op | b_op;
            OP_ADD:  alu_val = a_op + b_op;
            OP_XOR:  alu_val = a_op ^ b_op;
            OP_NOR:  alu_val = ~(a_op | b_op);
            OP_SUB:  alu_val = a_op - b_op;
            OP_SLT:  alu_val = {31'd0, ($signed(a_op) < $signed(b_op))};
            OP_SLL:  alu_val = bf_op << shamt;
            OP_SRL:  alu_val = bf_op >> shamt;
            OP_SRA:  alu_val = 32'($signed(bf_op) >>> shamt);
            OP_LUI:  alu_val = {imm[15:0], 16'h0000};
            default: alu_val = 32'd0;
        endcase
    end

`ifdef EX_MULT_EN
    localparam logic [3:0] OP_MULT = 4'b1100;
    localparam int         CNT_W   = $clog2(MULT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      mcand_reg, mcand_next;
    logic [31:0]      mplier_reg, mplier_next;
    logic [31:0]      prod_reg, prod_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // FSM state and multiplier datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            mcand_reg  <= 32'd0;
            mplier_reg <= 32'd0;
            prod_reg   <= 32'd0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            prod_reg   <= prod_next;
            count_reg  <= count_next;
        end
    end

    // Next-state, shift-add step, stall and EX/MEM selection (bubble by default)
    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
        count_next  = count_reg;
        stall       = 1'b0;
        res_next    = 32'd0;
        wdata_next  = 32'd0;
        waddr_next  = 5'd0;
        rw_next     = 1'b0;
        mr_next     = 1'b0;
        mw_next     = 1'b0;
        m2r_next    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (!flush) begin
                    if (alu_op_in == OP_MULT) begin
                        // Gated by reset so stall drops as soon as reset asserts
                        stall       = reset;
                        mcand_next  = a_op;
                        mplier_next = b_op;
                        prod_next   = 32'd0;
                        count_next  = '0;
                        state_next  = BUSY;
                    end else begin
                        res_next   = alu_val;
                        wdata_next = bf_op;
                        waddr_next = dest;
                        rw_next    = reg_write_in;
                        mr_next    = mem_read_in;
                        mw_next    = mem_write_in;
                        m2r_next   = mem_to_reg_in;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    stall       = 1'b1;
                    prod_next   = prod_reg + (mplier_reg[0] ? mcand_reg : 32'd0);
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    count_next  = count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                if (!flush) begin
                    // Upstream is still holding the MULT, so its controls are live
                    res_next   = prod_reg;
                    wdata_next = bf_op;
                    waddr_next = dest;
                    rw_next    = reg_write_in;
                    mr_next    = mem_read_in;
                    mw_next    = mem_write_in;
                    m2r_next   = mem_to_reg_in;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    // No multiplier: every code completes in one cycle, flush inserts a bubble
    always_comb begin
        stall      = 1'b0;
        res_next   = 32'd0;
        wdata_next = 32'd0;
        waddr_next = 5'd0;
        rw_next    = 1'b0;
        mr_next    = 1'b0;
        mw_next    = 1'b0;
        m2r_next   = 2'b00;
        if (!flush) begin
            res_next   = alu_val;
            wdata_next = bf_op;
            waddr_next = dest;
            rw_next    = reg_write_in;
            mr_next    = mem_read_in;
            mw_next    = mem_write_in;
            m2r_next   = mem_to_reg_in;
        end
    end
`endif

    // EX/MEM pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_result     <= 32'd0;
            write_data     <= 32'd0;
            w_addr         <= 5'd0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= 2'b00;
        end else begin
            alu_result     <= res_next;
            write_data     <= wdata_next;
            w_addr         <= waddr_next;
            reg_write_out  <= rw_next;
            mem_read_out   <= mr_next;
            mem_write_out  <= mw_next;
            mem_to_reg_out <= m2r_next;
        end
    end

    // Zero flag follows the registered result, so it reads 1 after reset and on bubbles
    assign zero_out = (alu_result == 32'd0);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and popped/compared when the stage produces it.
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reg_dst_in = 0, reg_write_in = 0, alu_src_in = 0;
    logic        mem_read_in = 0, mem_write_in = 0;
    logic [1:0]  mem_to_reg_in = 0;
    logic [3:0]  alu_op_in = 0;
    logic [31:0] r_data1 = 0, r_data2 = 0, imm = 0;
    logic [4:0]  rt = 0, rd = 0;
    logic [1:0]  fwd_a = 0, fwd_b = 0;
    logic [31:0] ex_mem_result = 0, mem_wb_result = 0;
    logic        flush = 0;
    logic [31:0] alu_result, write_data;
    logic [4:0]  w_addr;
    logic        zero_out, reg_write_out, mem_read_out, mem_write_out;
    logic [1:0]  mem_to_reg_out;
    logic        stall;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] wd;
        logic        wd_care;
        logic [4:0]  wa;
        logic        rw, mr, mw;
        logic [1:0]  m2r;
    } exp_t;

    exp_t sb[$];

    ex_stage dut (
        .clock(clock), .reset(reset),
        .reg_dst_in(reg_dst_in), .reg_write_in(reg_write_in), .alu_src_in(alu_src_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .alu_op_in(alu_op_in), .r_data1(r_data1), .r_data2(r_data2), .rt(rt), .rd(rd),
        .imm(imm), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_mem_result(ex_mem_result),
        .mem_wb_result(mem_wb_result), .flush(flush), .alu_result(alu_result),
        .write_data(write_data), .w_addr(w_addr), .zero_out(zero_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ctrl(input logic rw, input logic rdst, input logic asrc,
                        input logic mr, input logic mw, input logic [1:0] m2r);
        reg_write_in = rw; reg_dst_in = rdst; alu_src_in = asrc;
        mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r;
    endtask

    task automatic ops(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [1:0] fa, input logic [1:0] fb);
        alu_op_in = op; r_data1 = a; r_data2 = b; imm = im; fwd_a = fa; fwd_b = fb;
    endtask

    task automatic push(input string tag, input logic [31:0] res, input logic [31:0] wd,
                        input logic wd_care, input logic [4:0] wa, input logic rw,
                        input logic mr, input logic mw, input logic [1:0] m2r);
        exp_t e;
        e.tag = tag; e.res = res; e.wd = wd; e.wd_care = wd_care; e.wa = wa;
        e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        push(tag, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            $display("[TB] txn %s: alu_result=%h write_data=%h w_addr=%0d rw=%b mr=%b mw=%b m2r=%b zero=%b",
                     e.tag, alu_result, write_data, w_addr, reg_write_out, mem_read_out,
                     mem_write_out, mem_to_reg_out, zero_out);
            chk({e.tag, ".alu_result"}, alu_result, e.res);
            if (e.wd_care) chk({e.tag, ".write_data"}, write_data, e.wd);
            chk({e.tag, ".w_addr"}, 32'(w_addr), 32'(e.wa));
            chk({e.tag, ".reg_write"}, 32'(reg_write_out), 32'(e.rw));
            chk({e.tag, ".mem_read"}, 32'(mem_read_out), 32'(e.mr));
            chk({e.tag, ".mem_write"}, 32'(mem_write_out), 32'(e.mw));
            chk({e.tag, ".mem_to_reg"}, 32'(mem_to_reg_out), 32'(e.m2r));
            chk({e.tag, ".zero_out"}, 32'(zero_out), 32'(e.res == 32'd0));
        end
    endtask

`ifdef EX_MULT_EN
    int  n;
    logic bub_bad;
`endif

    initial begin
        // Reset state
        #2;
        chk("reset.alu_result", alu_result, 32'd0);
        chk("reset.w_addr", 32'(w_addr), 32'd0);
        chk("reset.reg_write", 32'(reg_write_out), 32'd0);
        chk("reset.zero_out", 32'(zero_out), 32'd1);
        chk("reset.stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // ADD with A forwarded from EX/MEM
        rt = 5'd2; rd = 5'd3; ex_mem_result = 32'd7; mem_wb_result = 32'd0;
        ctrl(1, 1, 0, 0, 0, 2'b00);
        ops(4'b0010, 32'd5, 32'd3, 32'd0, 2'b10, 2'b00);
        chk("add_fwd.stall", 32'(stall), 32'd0);
        push("add_fwd", 32'd10, 32'd3, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b0110, 32'd4, 32'd4, 32'd0, 2'b00, 2'b00);
        push("sub_zero", 32'd0, 32'd4, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        push("slt_neg", 32'd1, 32'd1, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b1010, 32'd0, 32'h8000_0000, 32'h0000_0100, 2'b00, 2'b00);
        push("sra", 32'hF800_0000, 32'h8000_0000, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b1001, 32'd0, 32'h8000_0000, 32'h0000_0100, 2'b00, 2'b00);
        push("srl", 32'h0800_0000, 32'h8000_0000, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b1000, 32'd0, 32'd1, 32'h0000_0100, 2'b00, 2'b00);
        push("sll", 32'h0000_0010, 32'd1, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        push("and", 32'h0000_F000, 32'h0000_FF00, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
        ops(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        push("or", 32'h0000_FFF0, 32'h0000_FF00, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
        ops(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00, 2'b00);
        push("xor", 32'h0000_0FF0, 32'h0000_FF00, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
        ops(4'b0100, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        push("nor", 32'hFFFF_FFFF, 32'd0, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        // LUI through the immediate path
        ctrl(1, 0, 1, 0, 0, 2'b00);
        ops(4'b1011, 32'd0, 32'd0, 32'h0000_1234, 2'b00, 2'b00);
        push("lui", 32'h1234_0000, 32'd0, 1, 5'd2, 1, 0, 0, 2'b00);
        step(); check_out();

        // fwd 11 selects the register; fwd_b 10 forwards EX/MEM into B
        ctrl(1, 1, 0, 0, 0, 2'b00);
        ex_mem_result = 32'd100; mem_wb_result = 32'd200;
        ops(4'b0010, 32'd2, 32'd3, 32'd0, 2'b11, 2'b11);
        push("fwd11", 32'd5, 32'd3, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
        ex_mem_result = 32'h20;
        ops(4'b0010, 32'd1, 32'd9, 32'd0, 2'b00, 2'b10);
        push("fwdb10", 32'h21, 32'h20, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        ops(4'b0101, 32'd6, 32'd7, 32'd0, 2'b00, 2'b00);
        push("undef_op", 32'd0, 32'd7, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        // Store: address from imm, data forwarded from MEM/WB
        rt = 5'd5; mem_wb_result = 32'hDEAD_BEEF;
        ctrl(0, 0, 1, 0, 1, 2'b00);
        ops(4'b0010, 32'h100, 32'h0, 32'hFFFF_FFFC, 2'b00, 2'b01);
        push("store", 32'h0000_00FC, 32'hDEAD_BEEF, 1, 5'd5, 0, 0, 1, 2'b00);
        step(); check_out();

        // Load: mem_read and mem_to_reg pass through
        ctrl(1, 0, 1, 1, 0, 2'b01);
        ops(4'b0010, 32'h40, 32'h0, 32'd8, 2'b00, 2'b00);
        push("load", 32'h48, 32'h0, 1, 5'd5, 1, 1, 0, 2'b01);
        step(); check_out();

        // Flush in IDLE squashes the instruction
        flush = 1'b1;
        ctrl(1, 1, 0, 1, 1, 2'b10);
        ops(4'b0010, 32'd1, 32'd1, 32'd0, 2'b00, 2'b00);
        push_bubble("flush_idle");
        step(); check_out();
        flush = 1'b0;

        // MULT 0x00010003 x 5 -> rd 9
        rd = 5'd9;
        ctrl(1, 1, 0, 0, 0, 2'b00);
        ops(4'b1100, 32'h0001_0003, 32'd5, 32'd0, 2'b00, 2'b00);
`ifdef EX_MULT_EN
        push("mult", 32'h0005_000F, 32'd5, 0, 5'd9, 1, 0, 0, 2'b00);
        n = 0; bub_bad = 1'b0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            step();
            if (alu_result !== 32'd0 || reg_write_out !== 1'b0 || w_addr !== 5'd0)
                bub_bad = 1'b1;
        end
        chk("mult.stall_cycles", 32'(n), 32'd33);
        chk("mult.bubbles", 32'(bub_bad), 32'd0);
        chk("mult.done_stall", 32'(stall), 32'd0);
        step(); check_out();

        // Flush at BUSY iteration 10
        step();
        for (int i = 0; i < 9; i++) step();
        chk("mflush.busy_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("mflush.stall_drop", 32'(stall), 32'd0);
        push_bubble("mflush_bubble");
        step(); check_out();
        flush = 1'b0;
        rd = 5'd3;
        ops(4'b0010, 32'd20, 32'd22, 32'd0, 2'b00, 2'b00);
        chk("mflush.idle_stall", 32'(stall), 32'd0);
        push("add_after_flush", 32'd42, 32'd22, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
`else
        chk("mult_off.stall", 32'(stall), 32'd0);
        push("mult_off", 32'd0, 32'd5, 1, 5'd9, 1, 0, 0, 2'b00);
        step(); check_out();
        chk("mult_off.stall_after", 32'(stall), 32'd0);
        rd = 5'd3;
`endif

        // Async reset between edges clears a live result immediately
        ops(4'b0010, 32'd5, 32'd3, 32'd0, 2'b00, 2'b00);
        push("pre_reset", 32'd8, 32'd3, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();
        #2;
        reset = 1'b0;
        #1;
        chk("areset.alu_result", alu_result, 32'd0);
        chk("areset.w_addr", 32'(w_addr), 32'd0);
        chk("areset.reg_write", 32'(reg_write_out), 32'd0);
        chk("areset.stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

`ifdef EX_MULT_EN
        // Async reset while the multiplier is BUSY
        ops(4'b1100, 32'd3, 32'd4, 32'd0, 2'b00, 2'b00);
        step(); step(); step();
        chk("busy_reset.pre_stall", 32'(stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("busy_reset.stall", 32'(stall), 32'd0);
        chk("busy_reset.alu_result", alu_result, 32'd0);
        ops(4'b0010, 32'd5, 32'd3, 32'd0, 2'b00, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        step();
        check_pending_none: ;
`endif

        // Normal operation resumes with latency 1
        ops(4'b0110, 32'd50, 32'd8, 32'd0, 2'b00, 2'b00);
        chk("resume.stall", 32'(stall), 32'd0);
        push("resume_sub", 32'd42, 32'd8, 1, 5'd3, 1, 0, 0, 2'b00);
        step(); check_out();

        chk("scoreboard.leftover", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Consumes the ID/EX register outputs and resolves forwarding for both operands.
- Computes the ALU result and registers everything into the EX/MEM boundary.
- Owns an iterative 32-cycle multiplier and raises stall toward IF/ID/ID-EX while it is busy.

Parameters:
- MULT_CYCLES, 32, number of shift-add iterations performed in BUSY; must be 32 for full-width operands.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- reg_dst_in, reg_write_in, alu_src_in, mem_read_in, mem_write_in  in  1 each  ID/EX control outputs
- mem_to_reg_in  in  2  ID/EX control
- alu_op_in  in  4  ALU operation
- r_data1, r_data2  in  32 each  register-file operands
- rt, rd  in  5 each  register addresses
- imm  in  32  sign-extended immediate; imm[10:6] is shamt
- fwd_a, fwd_b  in  2 each  forward select: 00 = register, 01 = mem_wb_result, 10 = ex_mem_result, 11 = register
- ex_mem_result, mem_wb_result  in  32 each  forwarded values
- flush  in  1  squash the current EX instruction
- alu_result  out  32  registered result
- write_data  out  32  registered forwarded B operand (store data)
- w_addr  out  5  registered destination address
- zero_out  out  1  registered (result == 0)
- reg_write_out, mem_read_out, mem_write_out  out  1 each  registered controls
- mem_to_reg_out  out  2  registered control
- stall  out  1  combinational; hold upstream stages

Behaviour:
- Reset (async, reset=0): all outputs 0, FSM to IDLE, multiplier registers 0.
- Operand selection:
  - A = fwd_a-selected r_data1.
  - Bf = fwd_b-selected r_data2.
  - B = alu_src_in ? imm : Bf.
- alu_op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
  - 0110 SUB.
  - 0111 SLT (signed; result 1 or 0).
  - 1000 SLL, 1001 SRL, 1010 SRA: shift Bf by imm[10:6].
  - 1011 LUI: {imm[15:0], 16'h0}.
  - 1100 MULT: low 32 bits of A*B, unsigned.
  - Any other code: result 0.
- Arithmetic is 32-bit and wraps modulo 2^32; no overflow trap.
- w_addr = reg_dst_in ? rd : rt.
- Single-cycle ops: result and controls captured at the next rising edge (latency 1). stall stays 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if alu_op_in == MULT and !flush, then stall=1, load multiplicand, multiplier and counter, go to BUSY. The EX/MEM outputs take a bubble (all controls 0, data 0).
  - BUSY: stall=1; one shift-add step per edge; bubble on the outputs. After MULT_CYCLES edges go to DONE.
  - DONE: stall=0; at the edge, outputs load the product, w_addr and the MULT instruction's controls; go to IDLE.
  - First MULT result is visible MULT_CYCLES+2 edges after the instruction is first presented.
- stall = (IDLE & alu_op_in==MULT & !flush) | BUSY. It is 0 in DONE.
- Upstream holds all inputs stable while stall=1. Forwarding inputs are sampled only at accept.
- flush:
  - Any state: the next edge captures a bubble (controls 0, data 0).
  - In BUSY or DONE: abort to IDLE, and stall falls combinationally in the same cycle.
  - flush together with MULT in IDLE: not accepted, stall=0.
- zero_out = (registered alu_result == 0). It is 1 after reset and 1 on bubbles.
- Reset asserted mid-MULT: immediate return to IDLE, stall=0, outputs 0.

Optional Feature:
- EX_MULT_EN defined: MULT (1100) uses the BUSY/DONE iterative multiplier described above.
- EX_MULT_EN undefined:
  - No multiplier registers are instantiated and the FSM stays in IDLE.
  - 1100 is treated as an undefined code: result 0, latency 1.
  - stall is tied to 0.

Test Plan:
- ADD forward: r_data1=5, fwd_a=10, ex_mem_result=7, r_data2=3, alu_src=0, op=0010 -> next edge alu_result=10, zero_out=0, stall=0.
- SUB/SLT/SRA:
  - SUB 4-4 -> alu_result 0, zero_out=1.
  - SLT -1 vs 1 -> 1.
  - SRA of 0x80000000 with imm[10:6]=4 -> 0xF8000000.
- Store path: alu_src=1, imm=0xFFFFFFFC, r_data1=0x100, fwd_b=01, mem_wb_result=0xDEADBEEF, mem_write_in=1 -> alu_result=0xFC, write_data=0xDEADBEEF, mem_write_out=1.
- MULT (EX_MULT_EN): 0x00010003 x 0x00000005 held stable, reg_write_in=1, reg_dst=1, rd=9:
  - stall high for 33 cycles, with bubbles on the outputs.
  - DONE edge gives alu_result=0x0005000F, w_addr=9, reg_write_out=1.
  - stall=0 in DONE.
- Flush mid-MULT: assert flush at BUSY iteration 10 -> stall falls in that cycle, next output is a bubble, FSM returns to IDLE; the following ADD completes with latency 1.
- Async reset: drop reset mid-BUSY between clock edges -> all outputs 0 and stall 0 immediately; normal operation resumes after release.
